// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared arbitration modes and default parameters for the multi-port memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam int DEF_NUM_PORTS  = 3;
    localparam int DEF_N          = 4;
    localparam int DEF_ADDR_LINES = 2;
    localparam int DEF_WORDSIZE   = 2;
    localparam int DEF_MODE       = MODE_RR;

    function automatic arb_mode_e mode_from_int(input int m);
        return (m == MODE_FIXED) ? ARB_FIXED : ARB_RR;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - one-hot grant generator, fixed priority or round-robin with pointer register
module rr_grant
    import mem_arb_pkg::*;
#(
    parameter int NP = DEF_NUM_PORTS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NP-1:0]  req,
    input  arb_mode_e      mode,
    output logic [NP-1:0]  gnt
);

    localparam int PW = $clog2(NP);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;

    // Loops run from the far end so the closest eligible port is assigned last and wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        cand  = '0;
        if (rst_n) begin
            if (mode == ARB_FIXED) begin
                for (int i = NP - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        gnt = NP'(1) << i;
                    end
                end
            end else begin
                for (int k = NP; k >= 1; k--) begin
                    cand = PW'((int'(ptr_q) + k) % NP);
                    if (req[cand]) begin
                        gnt   = NP'(1) << cand;
                        ptr_d = cand;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(NP - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mport_mem_arbiter.sv
// rtl/mport_mem_arbiter.sv - multi-port arbitrated register memory with per-port registered read data
module mport_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int num_ports     = DEF_NUM_PORTS,
    parameter int N             = DEF_N,
    parameter int no_addr_lines = DEF_ADDR_LINES,
    parameter int wordsize      = DEF_WORDSIZE,
    parameter int mode          = DEF_MODE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [num_ports-1:0]              req,
    input  logic [num_ports-1:0]              write_enable,
    input  logic [num_ports*no_addr_lines-1:0] port_addr,
    input  logic [num_ports*wordsize-1:0]     port_data,
    output logic [num_ports-1:0]              gnt,
    output logic [num_ports*wordsize-1:0]     data_read,
    output logic [num_ports-1:0]              read_valid
);

    localparam arb_mode_e ARB_MODE = mode_from_int(mode);

    logic [wordsize-1:0]           mem_q [N];
    logic [wordsize-1:0]           mem_d [N];
    logic [num_ports*wordsize-1:0] data_read_q;
    logic [num_ports*wordsize-1:0] data_read_d;
    logic [num_ports-1:0]          read_valid_q;
    logic [num_ports-1:0]          read_valid_d;
    logic [no_addr_lines-1:0]      addr;
    logic [wordsize-1:0]           rdata;

    rr_grant #(
        .NP (num_ports)
    ) u_grant (
        .clk   (clk),
        .rst_n (rst),
        .req   (req),
        .mode  (ARB_MODE),
        .gnt   (gnt)
    );

    // Address decode by comparison keeps depth N exact; unmatched addresses write nothing and read 0.
    always_comb begin
        mem_d        = mem_q;
        data_read_d  = data_read_q;
        read_valid_d = '0;
        addr         = '0;
        rdata        = '0;
        for (int i = 0; i < num_ports; i++) begin
            if (gnt[i]) begin
                addr = port_addr[i*no_addr_lines +: no_addr_lines];
                if (write_enable[i]) begin
                    for (int j = 0; j < N; j++) begin
                        if (int'(addr) == j) begin
                            mem_d[j] = port_data[i*wordsize +: wordsize];
                        end
                    end
                end else begin
                    rdata = '0;
                    for (int j = 0; j < N; j++) begin
                        if (int'(addr) == j) begin
                            rdata = mem_q[j];
                        end
                    end
                    data_read_d[i*wordsize +: wordsize] = rdata;
                    read_valid_d[i]                     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) begin
                mem_q[j] <= '0;
            end
            data_read_q  <= '0;
            read_valid_q <= '0;
        end else begin
            mem_q        <= mem_d;
            data_read_q  <= data_read_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign data_read  = data_read_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_mport_mem_arbiter.sv
// tb/tb_mport_mem_arbiter.sv - self-checking bench: round-robin N=3 and fixed-priority N=4 instances
module tb_mport_mem_arbiter;

    localparam int P  = 3;
    localparam int AW = 2;
    localparam int W  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [P-1:0]   req = '0;
    logic [P-1:0]   we  = '0;
    logic [P*AW-1:0] addr = '0;
    logic [P*W-1:0] data = '0;

    logic [P-1:0]   gnt_r, rv_r, gnt_f, rv_f;
    logic [P*W-1:0] dr_r, dr_f;

    int total = 0;
    int bad   = 0;

    // Reference state, index 0 = round-robin N=3 instance, index 1 = fixed-priority N=4 instance
    int m_mem [2][4];
    int m_ptr [2];
    int m_dr  [2][P];
    int m_rv  [2][P];

    always #5 clk = ~clk;

    mport_mem_arbiter #(
        .num_ports(P), .N(3), .no_addr_lines(AW), .wordsize(W), .mode(1)
    ) dut_rr (
        .clk(clk), .rst(rst), .req(req), .write_enable(we), .port_addr(addr),
        .port_data(data), .gnt(gnt_r), .data_read(dr_r), .read_valid(rv_r)
    );

    mport_mem_arbiter #(
        .num_ports(P), .N(4), .no_addr_lines(AW), .wordsize(W), .mode(0)
    ) dut_fp (
        .clk(clk), .rst(rst), .req(req), .write_enable(we), .port_addr(addr),
        .port_data(data), .gnt(gnt_f), .data_read(dr_f), .read_valid(rv_f)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mode_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic int exp_gnt(input int d);
        if (!rst) return 0;
        if (mode_of(d) == 0) begin
            for (int i = 0; i < P; i++) if (req[i]) return 1 << i;
            return 0;
        end
        for (int k = 1; k <= P; k++) begin
            int idx;
            idx = (m_ptr[d] + k) % P;
            if (req[idx]) return 1 << idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 4; w++) m_mem[d][w] = 0;
            for (int i = 0; i < P; i++) begin
                m_dr[d][i] = 0;
                m_rv[d][i] = 0;
            end
            m_ptr[d] = P - 1;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int g;
            g = exp_gnt(d);
            for (int i = 0; i < P; i++) m_rv[d][i] = 0;
            for (int i = 0; i < P; i++) begin
                if (g == (1 << i)) begin
                    int a;
                    a = int'(addr[i*AW +: AW]);
                    if (we[i]) begin
                        if (a < n_of(d)) m_mem[d][a] = int'(data[i*W +: W]);
                    end else begin
                        m_dr[d][i] = (a < n_of(d)) ? m_mem[d][a] : 0;
                        m_rv[d][i] = 1;
                    end
                    if (mode_of(d) == 1) m_ptr[d] = i;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [P-1:0]   g_act, rv_act;
            logic [P*W-1:0] dr_act;
            g_act  = (d == 0) ? gnt_r : gnt_f;
            rv_act = (d == 0) ? rv_r  : rv_f;
            dr_act = (d == 0) ? dr_r  : dr_f;
            chk($sformatf("gnt_d%0d", d), 32'(g_act), 32'(exp_gnt(d)));
            for (int i = 0; i < P; i++) begin
                chk($sformatf("rv_d%0d_p%0d", d, i), 32'(rv_act[i]), 32'(m_rv[d][i]));
                chk($sformatf("dr_d%0d_p%0d", d, i), 32'(dr_act[i*W +: W]), 32'(m_dr[d][i]));
            end
        end
    end

    task automatic drive(input int p, input bit r, input bit w, input int a, input int dt);
        req[p]           = r;
        we[p]            = w;
        addr[p*AW +: AW] = AW'(a);
        data[p*W +: W]   = W'(dt);
    endtask

    task automatic clr();
        req  = '0;
        we   = '0;
        addr = '0;
        data = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        clr();
        cyc();
        cyc();
        @(negedge clk);
        #2 rst = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        cyc();
        cyc();
        // Reset holds everything low even with a pending request
        drive(0, 1, 0, 2, 0);
        @(negedge clk);
        chk("rst_gnt_r", 32'(gnt_r), 0);
        chk("rst_gnt_f", 32'(gnt_f), 0);
        chk("rst_rv_r", 32'(rv_r), 0);
        chk("rst_dr_r", 32'(dr_r), 0);
        clr();
        #2 rst = 1'b1;
        cyc();
        drive(0, 1, 0, 2, 0);
        @(negedge clk);
        chk("rd0_gnt", 32'(gnt_r), 1);
        cyc();
        clr();
        @(negedge clk);
        chk("rd0_rv", 32'(rv_r), 1);
        chk("rd0_dr", 32'(dr_r[1:0]), 0);
        cyc();
        @(negedge clk);
        chk("rd0_rv_drop", 32'(rv_r), 0);

        // Write contention, requests held until granted
        do_reset();
        drive(0, 1, 1, 2, 1);
        drive(1, 1, 1, 2, 3);
        drive(2, 1, 1, 2, 2);
        @(negedge clk);
        chk("wc_g0", 32'(gnt_r), 1);
        cyc();
        req[0] = 1'b0;
        @(negedge clk);
        chk("wc_g1", 32'(gnt_r), 2);
        cyc();
        req[1] = 1'b0;
        @(negedge clk);
        chk("wc_g2", 32'(gnt_r), 4);
        cyc();
        clr();
        drive(1, 1, 0, 2, 0);
        @(negedge clk);
        chk("wc_rd_gnt", 32'(gnt_r), 2);
        chk("wc_rd_rv_early", 32'(rv_r), 0);
        cyc();
        clr();
        @(negedge clk);
        chk("wc_rd_rv", 32'(rv_r), 2);
        chk("wc_rd_dr", 32'(dr_r[3:2]), 2);
        chk("wc_rd_dr_fp", 32'(dr_f[3:2]), 2);

        // Fairness under saturation
        do_reset();
        req = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("fair_r_%0d", k), 32'(gnt_r), 32'(1 << (k % 3)));
            chk($sformatf("fair_f_%0d", k), 32'(gnt_f), 1);
            cyc();
        end
        clr();

        // Fixed priority starves port 2
        req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("fp_%0d", k), 32'(gnt_f), 1);
            cyc();
        end
        clr();

        // Out-of-range address on the N=3 instance
        drive(0, 1, 1, 3, 3);
        @(negedge clk);
        chk("oor_wr_gnt", 32'(gnt_r), 1);
        cyc();
        clr();
        drive(0, 1, 0, 3, 0);
        @(negedge clk);
        cyc();
        clr();
        @(negedge clk);
        chk("oor_rv", 32'(rv_r), 1);
        chk("oor_dr", 32'(dr_r[1:0]), 0);
        chk("oor_dr_fp", 32'(dr_f[1:0]), 3);

        // Reset landing in the read_valid cycle
        drive(0, 1, 1, 1, 3);
        @(negedge clk);
        cyc();
        clr();
        drive(0, 1, 0, 1, 0);
        @(negedge clk);
        cyc();
        clr();
        @(negedge clk);
        chk("mr_rv_before", 32'(rv_r), 1);
        chk("mr_dr_before", 32'(dr_r[1:0]), 3);
        #2 rst = 1'b0;
        #1;
        chk("mr_rv_after", 32'(rv_r), 0);
        chk("mr_dr_after", 32'(dr_r), 0);
        chk("mr_gnt_after", 32'(gnt_r), 0);
        cyc();
        req = '1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mr_first_gnt_r", 32'(gnt_r), 1);
        chk("mr_first_gnt_f", 32'(gnt_f), 1);
        cyc();
        clr();

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            req  = P'($urandom);
            we   = P'($urandom);
            addr = (P*AW)'($urandom);
            data = (P*W)'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
            cyc();
        end
        clr();
        cyc();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
